jalu_seq: RTL and testbench

JALU_SEQ -- requirements
Module: jalu_seq

---
 rtl/jalu_seq_pkg.sv | 33 +++
 rtl/jalu_seq_jaluc.sv | 44 ++++
 rtl/jalu_seq.sv | 136 +++++++++++++
 tb/tb_jalu_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jalu_seq_pkg.sv
// ============================================================================
// Module      : jalu_seq_pkg
// Description : Shared op codes and FSM state encodings for jalu_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jalu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SHR = 3'b001,
    OP_SHL = 3'b010,
    OP_NOT = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_CMP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

endpackage : jalu_seq_pkg

`default_nettype wire

// File: rtl/jalu_seq_jaluc.sv
// ============================================================================
// Module      : jaluc
// Description : Single-cycle combinational datapath: add, logic ops, compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jaluc
  import jalu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] res,
  output logic             co,
  output logic             eq,
  output logic             alarger
);

  localparam logic [WIDTH-1:0] C_ZERO = '0;

  always_comb begin
    res = C_ZERO;
    co  = 1'b0;
    case (op_e'(op))
      OP_ADD:         {co, res} = {1'b0, a} + {1'b0, b} + {C_ZERO, ci};
      OP_NOT:         res = ~a;
      OP_AND:         res = a & b;
      OP_OR:          res = a | b;
      OP_XOR, OP_CMP: res = a ^ b;
      // Shift ops are sequenced by the parent; pass the operand through.
      default:        res = a;
    endcase
  end

  assign eq      = (a == b);
  assign alarger = (a > b);

endmodule : jaluc

`default_nettype wire

// File: rtl/jalu_seq.sv
// ============================================================================
// Module      : jalu_seq
// Description : Sequential ALU; single-cycle ops via jaluc, shifts one bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jalu_seq
  import jalu_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] c,
  output logic             co,
  output logic             eq,
  output logic             alarger,
  output logic             z
);

  localparam logic [SHW-1:0] C_CNT_ONE = SHW'(1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [SHW-1:0]   r_count;
  logic             r_ci;
  logic             r_shl;
  logic             w_accept;
  logic             w_is_shift;
  logic [SHW-1:0]   w_count_init;
  logic [WIDTH-1:0] w_res;
  logic             w_co;
  logic             w_eq;
  logic             w_gt;
  logic [WIDTH-1:0] w_step_val;
  logic             w_step_co;
  logic             w_last_step;

  jaluc #(
    .WIDTH (WIDTH)
  ) u_jaluc (
    .op      (op),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .res     (w_res),
    .co      (w_co),
    .eq      (w_eq),
    .alarger (w_gt)
  );

  assign w_accept     = start && (r_state == ST_IDLE);
  assign w_is_shift   = is_shift(op_e'(op));
  assign w_count_init = (shamt == '0) ? C_CNT_ONE : shamt;
  assign w_last_step  = (r_count == C_CNT_ONE);

  // SHR shifts toward the LSB with the fill entering at the MSB; SHL mirrors.
  assign w_step_val = r_shl ? {c[WIDTH-2:0], r_ci} : {r_ci, c[WIDTH-1:1]};
  assign w_step_co  = r_shl ? c[WIDTH-1] : c[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = w_is_shift ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (w_last_step) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_ci    <= 1'b0;
      r_shl   <= 1'b0;
      c       <= '0;
      co      <= 1'b0;
      eq      <= 1'b0;
      alarger <= 1'b0;
      z       <= 1'b0;
    end else if (w_accept) begin
      eq      <= w_eq;
      alarger <= w_gt;
      if (w_is_shift) begin
        c       <= a;
        r_count <= w_count_init;
        r_ci    <= ci;
        r_shl   <= (op_e'(op) == OP_SHL);
      end else begin
        c       <= w_res;
        co      <= w_co;
        z       <= (w_res == '0);
      end
    end else if (r_state == ST_SHIFT) begin
      c       <= w_step_val;
      co      <= w_step_co;
      r_count <= r_count - C_CNT_ONE;
      // z only tracks completed results, so it moves on the final step alone.
      if (w_last_step) begin
        z <= (w_step_val == '0);
      end
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

endmodule : jalu_seq

`default_nettype wire

// File: tb/tb_jalu_seq.sv
// ============================================================================
// Module      : tb_jalu_seq
// Description : Directed and random scoreboard bench for jalu_seq (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jalu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       ci;
  logic [2:0] shamt;
  logic       busy;
  logic       done;
  logic [7:0] c;
  logic       co;
  logic       eq;
  logic       alarger;
  logic       z;

  typedef struct packed {
    logic [7:0] c;
    logic       co;
    logic       z;
    logic       eq;
    logic       alarger;
    logic [7:0] lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  jalu_seq #(
    .WIDTH (8),
    .SHW   (3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .ci      (ci),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .c       (c),
    .co      (co),
    .eq      (eq),
    .alarger (alarger),
    .z       (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [7:0] c_, input logic co_, input logic z_,
                              input logic eq_, input logic al_, input logic [7:0] lat_);
    exp_t e;
    e.c = c_; e.co = co_; e.z = z_; e.eq = eq_; e.alarger = al_; e.lat = lat_;
    return e;
  endfunction

  // Reference behaviour written from the operation definitions.
  function automatic exp_t model(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                                 input logic cin, input logic [2:0] sh);
    exp_t       e;
    logic [8:0] sum;
    logic [7:0] v;
    int         n;
    e.eq = (aa == bb); e.alarger = (aa > bb); e.co = 1'b0; e.lat = 8'd1;
    n = (sh == 3'd0) ? 1 : int'(sh);
    v = aa;
    case (o)
      3'b000: begin sum = 9'(aa) + 9'(bb) + 9'(cin); e.c = sum[7:0]; e.co = sum[8]; end
      3'b001: begin
        for (int i = 0; i < n; i++) begin e.co = v[0]; v = {cin, v[7:1]}; end
        e.c = v; e.lat = 8'(n + 1);
      end
      3'b010: begin
        for (int i = 0; i < n; i++) begin e.co = v[7]; v = {v[6:0], cin}; end
        e.c = v; e.lat = 8'(n + 1);
      end
      3'b011: e.c = ~aa;
      3'b100: e.c = aa & bb;
      3'b101: e.c = aa | bb;
      default: e.c = aa ^ bb;
    endcase
    e.z = (e.c == 8'h00);
    return e;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [7:0] aa, input logic [7:0] bb,
                        input logic cin, input logic [2:0] sh);
    exp_t e;
    int   cyc;
    op = o; a = aa; b = bb; ci = cin; shamt = sh; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("latency", cyc, {24'b0, e.lat});
      check("c", {24'b0, c}, {24'b0, e.c});
      check("co", {31'b0, co}, {31'b0, e.co});
      check("z", {31'b0, z}, {31'b0, e.z});
      check("eq", {31'b0, eq}, {31'b0, e.eq});
      check("alarger", {31'b0, alarger}, {31'b0, e.alarger});
      a = ~aa; b = ~bb;
      tick();
      check("done_one_cycle", {31'b0, done}, 32'd0);
      check("busy_idle", {31'b0, busy}, 32'd0);
      check("c_hold", {24'b0, c}, {24'b0, e.c});
      check("z_hold", {31'b0, z}, {31'b0, e.z});
    end
  endtask

  initial begin
    exp_t       e;
    int         cyc;
    int         ndone;
    int         first;
    logic [2:0] ro;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [2:0] rs;

    reset = 1'b1; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00; ci = 1'b0; shamt = 3'd0;
    tick();
    start = 1'b1;
    tick();
    check("rst_c", {24'b0, c}, 32'd0);
    check("rst_co", {31'b0, co}, 32'd0);
    check("rst_eq", {31'b0, eq}, 32'd0);
    check("rst_alarger", {31'b0, alarger}, 32'd0);
    check("rst_z", {31'b0, z}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();

    sb.push_back(mk(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1));
    run_op(3'b000, 8'hF0, 8'h20, 1'b1, 3'd0);
    sb.push_back(mk(8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4));
    run_op(3'b001, 8'h81, 8'h00, 1'b0, 3'd3);
    sb.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3));
    run_op(3'b010, 8'h81, 8'h00, 1'b1, 3'd2);
    sb.push_back(mk(8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2));
    run_op(3'b001, 8'h81, 8'h00, 1'b0, 3'd0);
    sb.push_back(mk(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1));
    run_op(3'b111, 8'h5A, 8'h5A, 1'b1, 3'd0);
    sb.push_back(mk(8'h83, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    run_op(3'b111, 8'h03, 8'h80, 1'b0, 3'd0);
    sb.push_back(mk(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1));
    run_op(3'b011, 8'h00, 8'h00, 1'b1, 3'd0);
    sb.push_back(mk(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1));
    run_op(3'b100, 8'hF0, 8'h0F, 1'b1, 3'd0);
    sb.push_back(mk(8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1));
    run_op(3'b000, 8'hFF, 8'h01, 1'b0, 3'd0);
    sb.push_back(mk(8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 8'd8));
    run_op(3'b001, 8'h55, 8'h00, 1'b1, 3'd7);
    sb.push_back(mk(8'hF5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    run_op(3'b101, 8'h35, 8'hC4, 1'b1, 3'd0);
    sb.push_back(mk(8'hF1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1));
    run_op(3'b110, 8'h35, 8'hC4, 1'b1, 3'd0);

    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = (i % 5 == 0) ? ra : 8'($urandom);
      rc = 1'($urandom);
      rs = 3'($urandom);
      sb.push_back(model(ro, ra, rb, rc, rs));
      run_op(ro, ra, rb, rc, rs);
    end

    // A start pulsed during SHIFT must be dropped, not queued.
    sb.push_back(model(3'b010, 8'h81, 8'h00, 1'b0, 3'd7));
    op = 3'b010; a = 8'h81; b = 8'h00; ci = 1'b0; shamt = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; ndone = 0; first = -1;
    e = mk(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int k = 0; k < 20; k++) begin
      if (k == 1) begin
        start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin
          first = cyc;
          if (sb.size() > 0) e = sb.pop_front();
          check("repulse_c", {24'b0, c}, {24'b0, e.c});
          check("repulse_co", {31'b0, co}, {31'b0, e.co});
        end
      end
      tick();
      cyc++;
    end
    check("repulse_done_count", ndone, 32'd1);
    check("repulse_latency", first, 32'd8);
    check("repulse_c_hold", {24'b0, c}, {24'b0, e.c});

    // Reset in the middle of a shift aborts it without a done pulse.
    op = 3'b010; a = 8'h81; b = 8'h7F; ci = 1'b1; shamt = 3'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("midshift_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check("abort_c", {24'b0, c}, 32'd0);
    check("abort_co", {31'b0, co}, 32'd0);
    check("abort_eq", {31'b0, eq}, 32'd0);
    check("abort_alarger", {31'b0, alarger}, 32'd0);
    check("abort_z", {31'b0, z}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_jalu_seq

`default_nettype wire
